// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: definitions shared by the loader, the CPU and the
// instruction memory.
//   - default instruction-memory geometry (address width, word width, depth)
//   - loader FSM state encoding (7 states, 3 bits)
package imem_loader_pkg;

   localparam int IMEM_M    = 16;   // word address width
   localparam int IMEM_N    = 32;   // instruction word width
   localparam int IMEM_SIZE = 512;  // depth in words

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_LO = 3'd1,
      LEN_HI = 3'd2,
      DATA   = 3'd3,
      WRITE  = 3'd4,
      DONE   = 3'd5,
      ERR    = 3'd6
   } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles 4 bytes into a little-endian 32-bit word.
//   clk, rst    : clock, async active-high reset
//   clr         : restart assembly at byte 0
//   accept      : byte_in is taken on this rising edge
//   byte_in     : incoming byte
//   word_next   : the word as it will look once byte_in is shifted in
//   word_ready  : the byte being accepted completes a word
module byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        accept,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_next,
   output logic        word_ready
);

   logic [1:0]  idx;
   logic [31:0] word;

   // New bytes enter at the top and shift down, so after four bytes the
   // first one sits in [7:0] and the last one in [31:24].
   assign word_next  = {byte_in, word[31:8]};
   assign word_ready = accept && (idx == 2'd3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx  <= 2'd0;
         word <= 32'd0;
      end else if (clr) begin
         idx  <= 2'd0;
         word <= 32'd0;
      end else if (accept) begin
         idx  <= idx + 2'd1;
         word <= word_next;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed byte image into instruction memory.
// Stream format: len[7:0], len[15:8], then len words of 4 little-endian bytes.
//   clk, rst          : clock, async active-high reset
//   start             : 1-cycle pulse opening a session (ignored while busy)
//   byte_valid/data   : source byte handshake, taken when byte_ready is high
//   byte_ready        : loader can take a byte this cycle
//   mem_we/addr/wdata : instruction-memory write port (word addressed)
//   busy              : session in progress; holds the CPU off the fetch path
//   done / error      : session finished / aborted (levels until next start)
//   word_count        : words written in the current session
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int M        = IMEM_M,
   parameter int N        = IMEM_N,
   parameter int MEM_SIZE = IMEM_SIZE
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         byte_valid,
   input  logic [7:0]   byte_data,
   output logic         byte_ready,
   output logic         mem_we,
   output logic [M-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   output logic         busy,
   output logic         done,
   output logic         error,
   output logic [M-1:0] word_count
);

   // Wide enough to compare the word counter with the 16-bit length.
   localparam int CW = (M > 16) ? M : 16;

   state_t        state;
   logic [15:0]   len;
   logic [15:0]   full_len;
   logic [CW-1:0] cnt_next;
   logic          accept;
   logic          pack_clr;
   logic [31:0]   word_next;
   logic          word_ready;

   assign accept   = byte_valid && byte_ready;
   assign full_len = {byte_data, len[7:0]};
   assign cnt_next = CW'(word_count) + CW'(1);
   assign pack_clr = start && !busy;

   byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clr        (pack_clr),
      .accept     (accept && (state == DATA)),
      .byte_in    (byte_data),
      .word_next  (word_next),
      .word_ready (word_ready)
   );

   // Outputs are registered alongside the state, so every transition sets
   // the flag values that belong to the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         len        <= 16'd0;
         byte_ready <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         word_count <= '0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  state      <= LEN_LO;
                  byte_ready <= 1'b1;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  error      <= 1'b0;
                  word_count <= '0;
                  len        <= 16'd0;
               end
            end
            LEN_LO: begin
               if (accept) begin
                  len[7:0] <= byte_data;
                  state    <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (accept) begin
                  len[15:8] <= byte_data;
                  if (full_len == 16'd0) begin
                     state      <= DONE;
                     byte_ready <= 1'b0;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                  end else if (int'(full_len) > MEM_SIZE) begin
                     state      <= ERR;
                     byte_ready <= 1'b0;
                     busy       <= 1'b0;
                     error      <= 1'b1;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               // Capture the completed word (including this last byte) so
               // the write port is stable for the whole WRITE cycle.
               if (word_ready) begin
                  state      <= WRITE;
                  byte_ready <= 1'b0;
                  mem_we     <= 1'b1;
                  mem_addr   <= word_count;
                  mem_wdata  <= N'(word_next);
               end
            end
            WRITE: begin
               word_count <= M'(cnt_next);
               if (cnt_next == CW'(len)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state      <= DATA;
                  byte_ready <= 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               byte_ready <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
